fp32_bn_collector: RTL and testbench
====================================

FP32_BN_COLLECTOR -- requirements
Module: fp32_bn_collector

Interface
REQ-001 SHALL have parameters: DEPTH, default 16, result FIFO entries (power of 2, >=2); TIMEOUT, default 64, idle cycles allowed with results outstanding.
REQ-002 SHALL have ports (name  direction  width  meaning):
 clk  in  1  single clock, rising edge;
 rst  in  1  reset, synchronous, active-high;
 issue  in  1  one pulse per sample accepted by the upstream normalizer;
 y_in  in  32  FP32 normalizer result;
 y_valid_in  in  1  single-cycle result strobe (no backpressure possible);
 clear  in  1  synchronous soft clear;
 m_data  out  32  buffered FP32 result;
 m_idx  out  16  sequence index of m_data;
 m_class  out  4  {nan, inf, zero, subnormal} of m_data;
 m_valid  out  1  output data valid;
 m_ready  in  1  downstream accept;
 outstanding  out  8  issued minus returned count;
 drop_cnt  out  16  results lost to FIFO full;
 err_timeout  out  1  sticky timeout flag;
 err_unexp  out  1  sticky flag: result with nothing outstanding;
 busy  out  1  state != IDLE.

Function
REQ-003 SHALL push {y_in, idx, class} into the FIFO on y_valid_in when not full, or when full with m_valid & m_ready in the same cycle.
REQ-004 SHALL drop y_in when full without a same-cycle pop, and increment drop_cnt (saturating at 0xFFFF).
REQ-005 SHALL assign idx from a 16-bit counter, incremented on every y_valid_in (pushed or dropped) and wrapping 0xFFFF->0, so gaps mark drops.
REQ-006 SHALL compute class from y_in at push: nan = exp 0xFF & mant!=0; inf = exp 0xFF & mant==0; zero = exp 0 & mant 0; subnormal = exp 0 & mant!=0.
REQ-007 SHALL present the FIFO head on m_data/m_idx/m_class with m_valid = !empty; output SHALL be stable while m_valid & !m_ready.
REQ-008 SHALL have a minimum latency of one cycle from y_valid_in to m_valid into an empty FIFO.
REQ-009 outstanding SHALL be +1 on issue, -1 on y_valid_in, unchanged on both, saturating at 255 and 0.
REQ-010 y_valid_in with outstanding==0 and no same-cycle issue SHALL set err_unexp; the sample is still processed per REQ-003/004.
REQ-011 SHALL implement FSM IDLE/RUN/DRAIN/TOUT:
 IDLE->RUN on outstanding becoming >0;
 RUN->DRAIN when outstanding reaches 0 with FIFO non-empty, RUN->IDLE when both are zero;
 DRAIN->IDLE on FIFO empty, DRAIN->RUN on issue;
 RUN->TOUT when the idle counter reaches TIMEOUT;
 TOUT->RUN on y_valid_in with outstanding still >0, TOUT->DRAIN/IDLE per the RUN rules.
REQ-012 The idle counter SHALL reset on y_valid_in or on outstanding==0, increment otherwise in RUN, and entering TOUT SHALL set err_timeout.
REQ-013 clear SHALL have the same effect as rst on all state, counters, FIFO and flags; rst takes priority.

Reset
REQ-014 On rst SHALL set m_valid=0, m_data=0, m_idx=0, m_class=0, outstanding=0, drop_cnt=0, err_timeout=0, err_unexp=0, busy=0, FSM=IDLE, FIFO empty and idx counter 0.
REQ-015 rst mid-operation SHALL discard buffered results with no output on the following cycle.

Structure
REQ-016 FSM state encoding, FP32 field constants (EXP_MAX=8'hFF) and the class bit positions SHALL live in a shared package used by the fp32 blocks.
REQ-017 The FIFO SHALL be a sub-module named fp32_sync_fifo (DEPTH, WIDTH=52), registered-output and first-word-fall-through.

Verification
REQ-018 Directed scenarios:
 (1) 3 issue pulses, then y_valid_in with 0x3F800000, 0xC0000000, 0x7FC00000 and m_ready=1 -> m_data in order, m_idx 0,1,2, m_class of the third =4'b1000, outstanding returns 0, FSM ends in IDLE.
 (2) m_ready=0, 18 results with DEPTH=16 -> 16 buffered, drop_cnt=2; after release, m_idx runs 0..15 and the next accepted result has m_idx=18.
 (3) Full FIFO, y_valid_in with a same-cycle pop -> no drop, drop_cnt unchanged.
 (4) 1 issue and no result for 64 cycles -> err_timeout=1 and FSM=TOUT; a late result returns FSM to IDLE and err_timeout stays 1 until clear.
 (5) y_valid_in with outstanding=0 -> err_unexp=1 and data still delivered; simultaneous issue+y_valid leaves outstanding unchanged.
 (6) rst asserted with 5 entries buffered -> next cycle m_valid=0, all counters 0, busy=0.

Source files
------------

// File: rtl/fp32_bn_pkg.sv
// Shared constants for the fp32 batch-norm result path:
// FSM encoding, FP32 field limits and class bit positions.
package fp32_bn_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_TOUT  = 2'd3;

    localparam logic [7:0] EXP_MAX  = 8'hFF;
    localparam logic [7:0] EXP_ZERO = 8'h00;

    localparam int CLS_SUB  = 0;
    localparam int CLS_ZERO = 1;
    localparam int CLS_INF  = 2;
    localparam int CLS_NAN  = 3;

    localparam int ENTRY_W = 52;

    function automatic logic [3:0] fp32_class(input logic [31:0] v);
        logic [3:0] c;
        logic       mz;
        mz = (v[22:0] == 23'd0);
        c = 4'd0;
        c[CLS_NAN]  = (v[30:23] == EXP_MAX) && !mz;
        c[CLS_INF]  = (v[30:23] == EXP_MAX) && mz;
        c[CLS_ZERO] = (v[30:23] == EXP_ZERO) && mz;
        c[CLS_SUB]  = (v[30:23] == EXP_ZERO) && !mz;
        return c;
    endfunction

endpackage

// File: rtl/fp32_sync_fifo.sv
// First-word-fall-through FIFO whose head is held in a register;
// the head register reads zero whenever the FIFO is empty.
module fp32_sync_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 52
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             full
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    rd_nxt;
    logic [AW:0]      cnt;
    logic [AW:0]      cnt_pop;
    logic [AW:0]      cnt_nxt;
    logic             do_push;
    logic             do_pop;

    assign empty   = (cnt == '0);
    assign full    = (cnt == (AW+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_comb begin
        rd_nxt  = rd_ptr + AW'(do_pop);
        cnt_pop = cnt - (AW+1)'(do_pop);
        cnt_nxt = cnt_pop + (AW+1)'(do_push);
    end

    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= din;
    end

    // Head is the incoming word only when nothing else remains after the pop.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            dout   <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + 1'b1;
            rd_ptr <= rd_nxt;
            cnt    <= cnt_nxt;
            if (cnt_nxt == '0)
                dout <= '0;
            else if (cnt_pop == '0)
                dout <= din;
            else
                dout <= mem[rd_nxt];
        end
    end

endmodule

// File: rtl/fp32_bn_collector.sv
// Collects FP32 normalizer results into a FIFO, tags them with a sequence
// index and class, and tracks outstanding work with a timeout watchdog.
module fp32_bn_collector
    import fp32_bn_pkg::*;
#(
    parameter int DEPTH   = 16,
    parameter int TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        issue,
    input  logic [31:0] y_in,
    input  logic        y_valid_in,
    input  logic        clear,
    output logic [31:0] m_data,
    output logic [15:0] m_idx,
    output logic [3:0]  m_class,
    output logic        m_valid,
    input  logic        m_ready,
    output logic [7:0]  outstanding,
    output logic [15:0] drop_cnt,
    output logic        err_timeout,
    output logic        err_unexp,
    output logic        busy
);

    localparam int IW = $clog2(TIMEOUT + 1);

    logic               srst;
    logic               empty;
    logic               full;
    logic               push;
    logic               pop;
    logic [15:0]        idx;
    logic [1:0]         state;
    logic [1:0]         state_nxt;
    logic [7:0]         outs_nxt;
    logic [IW-1:0]      idle_cnt;
    logic [ENTRY_W-1:0] head;

    assign srst    = rst || clear;
    assign m_valid = !empty;
    assign pop     = !empty && m_ready;
    assign push    = y_valid_in && (!full || pop);
    assign busy    = (state != ST_IDLE);
    assign m_data  = head[51:20];
    assign m_idx   = head[19:4];
    assign m_class = head[3:0];

    fp32_sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (srst),
        .push  (push),
        .din   ({y_in, idx, fp32_class(y_in)}),
        .pop   (pop),
        .dout  (head),
        .empty (empty),
        .full  (full)
    );

    always_comb begin
        outs_nxt = outstanding;
        if (issue && !y_valid_in && outstanding != 8'hFF)
            outs_nxt = outstanding + 8'd1;
        else if (!issue && y_valid_in && outstanding != 8'h00)
            outs_nxt = outstanding - 8'd1;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:
                if (outstanding != 8'h00)
                    state_nxt = ST_RUN;
            ST_RUN:
                if (outstanding == 8'h00)
                    state_nxt = empty ? ST_IDLE : ST_DRAIN;
                else if (!y_valid_in && idle_cnt == IW'(TIMEOUT - 1))
                    state_nxt = ST_TOUT;
            ST_DRAIN:
                if (issue)
                    state_nxt = ST_RUN;
                else if (empty)
                    state_nxt = ST_IDLE;
            ST_TOUT:
                if (outstanding == 8'h00)
                    state_nxt = empty ? ST_IDLE : ST_DRAIN;
                else if (y_valid_in && outs_nxt != 8'h00)
                    state_nxt = ST_RUN;
            default:
                state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            state       <= ST_IDLE;
            outstanding <= 8'd0;
            drop_cnt    <= 16'd0;
            idx         <= 16'd0;
            idle_cnt    <= '0;
            err_timeout <= 1'b0;
            err_unexp   <= 1'b0;
        end else begin
            state       <= state_nxt;
            outstanding <= outs_nxt;
            if (y_valid_in)
                idx <= idx + 16'd1;
            if (y_valid_in && !push && drop_cnt != 16'hFFFF)
                drop_cnt <= drop_cnt + 16'd1;
            if (y_valid_in && outstanding == 8'h00 && !issue)
                err_unexp <= 1'b1;
            if (state_nxt == ST_TOUT && state != ST_TOUT)
                err_timeout <= 1'b1;
            // Only quiet cycles with work pending count towards the timeout.
            if (state == ST_RUN && !y_valid_in && outstanding != 8'h00)
                idle_cnt <= idle_cnt + 1'b1;
            else
                idle_cnt <= '0;
        end
    end

endmodule

// File: tb/tb_fp32_bn_collector.sv
// Directed bench for fp32_bn_collector: ordering, overflow, timeout,
// unexpected results and mid-run reset.
module tb_fp32_bn_collector;
    import fp32_bn_pkg::*;

    logic        clk = 1'b0;
    logic        rst, issue, y_valid_in, clear, m_ready;
    logic [31:0] y_in;
    logic [31:0] m_data;
    logic [15:0] m_idx;
    logic [3:0]  m_class;
    logic        m_valid, err_timeout, err_unexp, busy;
    logic [7:0]  outstanding;
    logic [15:0] drop_cnt;

    int n_cmp = 0;
    int n_bad = 0;
    logic [51:0] mon_q [$];
    logic [51:0] got;

    fp32_bn_collector #(.DEPTH(16), .TIMEOUT(64)) dut (
        .clk(clk), .rst(rst), .issue(issue), .y_in(y_in),
        .y_valid_in(y_valid_in), .clear(clear), .m_data(m_data),
        .m_idx(m_idx), .m_class(m_class), .m_valid(m_valid),
        .m_ready(m_ready), .outstanding(outstanding),
        .drop_cnt(drop_cnt), .err_timeout(err_timeout),
        .err_unexp(err_unexp), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk)
        if (!rst && !clear && m_valid && m_ready)
            mon_q.push_back({m_data, m_idx, m_class});

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
        mon_q.delete();
    endtask

    task automatic send(input logic [31:0] v);
        y_in = v;
        y_valid_in = 1'b1;
        step();
        y_valid_in = 1'b0;
    endtask

    task automatic pulse_issue(input int n);
        for (int i = 0; i < n; i++) begin
            issue = 1'b1;
            step();
            issue = 1'b0;
        end
    endtask

    task automatic test_reset();
        n_cmp++;
        if ({m_valid, busy, err_timeout, err_unexp} !== 4'b0) begin
            n_bad++;
            $display("FAIL reset_flags got %b want 0000",
                     {m_valid, busy, err_timeout, err_unexp});
        end
        n_cmp++;
        if ({m_data, m_idx, m_class, outstanding, drop_cnt} !== 76'd0) begin
            n_bad++;
            $display("FAIL reset_values got %h want 0",
                     {m_data, m_idx, m_class, outstanding, drop_cnt});
        end
    endtask

    task automatic test_in_order();
        logic [51:0] exp [3];
        exp[0] = {32'h3F800000, 16'd0, 4'b0000};
        exp[1] = {32'hC0000000, 16'd1, 4'b0000};
        exp[2] = {32'h7FC00000, 16'd2, 4'b1000};
        do_reset();
        m_ready = 1'b1;
        pulse_issue(3);
        n_cmp++;
        if (outstanding !== 8'd3 || busy !== 1'b1) begin
            n_bad++;
            $display("FAIL order_issue got %0d/%b want 3/1", outstanding, busy);
        end
        send(32'h3F800000);
        send(32'hC0000000);
        send(32'h7FC00000);
        repeat (6) step();
        n_cmp++;
        if (mon_q.size() !== 3) begin
            n_bad++;
            $display("FAIL order_count got %0d want 3", mon_q.size());
        end
        for (int i = 0; i < 3; i++) begin
            got = (mon_q.size() > 0) ? mon_q.pop_front() : 52'd0;
            n_cmp++;
            if (got !== exp[i]) begin
                n_bad++;
                $display("FAIL order_beat%0d got %h want %h", i, got, exp[i]);
            end
        end
        n_cmp++;
        if (outstanding !== 8'd0 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL order_end got %0d/%b want 0/0", outstanding, busy);
        end
    endtask

    task automatic test_overflow();
        do_reset();
        m_ready = 1'b0;
        pulse_issue(19);
        for (int i = 0; i < 18; i++)
            send(32'h40000000 + 32'(i));
        n_cmp++;
        if (drop_cnt !== 16'd2) begin
            n_bad++;
            $display("FAIL ovf_drop got %0d want 2", drop_cnt);
        end
        repeat (3) step();
        n_cmp++;
        if ({m_valid, m_data, m_idx} !== {1'b1, 32'h40000000, 16'd0}) begin
            n_bad++;
            $display("FAIL ovf_hold got %b %h %0d want 1 40000000 0",
                     m_valid, m_data, m_idx);
        end
        m_ready = 1'b1;
        repeat (20) step();
        n_cmp++;
        if (mon_q.size() !== 16) begin
            n_bad++;
            $display("FAIL ovf_count got %0d want 16", mon_q.size());
        end
        for (int i = 0; i < 16; i++) begin
            got = (mon_q.size() > 0) ? mon_q.pop_front() : 52'd0;
            n_cmp++;
            if (got[51:4] !== {32'h40000000 + 32'(i), 16'(i)}) begin
                n_bad++;
                $display("FAIL ovf_beat%0d got %h want idx %0d", i, got, i);
            end
        end
        send(32'h41000000);
        repeat (3) step();
        got = (mon_q.size() > 0) ? mon_q.pop_front() : 52'd0;
        n_cmp++;
        if (got !== {32'h41000000, 16'd18, 4'b0000}) begin
            n_bad++;
            $display("FAIL ovf_next got %h want idx 18", got);
        end
    endtask

    task automatic test_full_pop();
        do_reset();
        m_ready = 1'b0;
        pulse_issue(17);
        for (int i = 0; i < 16; i++)
            send(32'h42000000 + 32'(i));
        m_ready = 1'b1;
        send(32'h43000000);
        m_ready = 1'b0;
        n_cmp++;
        if (drop_cnt !== 16'd0) begin
            n_bad++;
            $display("FAIL fullpop_drop got %0d want 0", drop_cnt);
        end
        m_ready = 1'b1;
        repeat (20) step();
        n_cmp++;
        if (mon_q.size() !== 17) begin
            n_bad++;
            $display("FAIL fullpop_count got %0d want 17", mon_q.size());
        end
        got = (mon_q.size() > 0) ? mon_q[$] : 52'd0;
        n_cmp++;
        if (got !== {32'h43000000, 16'd16, 4'b0000}) begin
            n_bad++;
            $display("FAIL fullpop_last got %h want idx 16", got);
        end
    endtask

    task automatic test_timeout();
        do_reset();
        m_ready = 1'b1;
        pulse_issue(1);
        repeat (30) step();
        n_cmp++;
        if (err_timeout !== 1'b0 || busy !== 1'b1) begin
            n_bad++;
            $display("FAIL tout_early got %b/%b want 0/1", err_timeout, busy);
        end
        repeat (50) step();
        n_cmp++;
        if (err_timeout !== 1'b1 || dut.state !== ST_TOUT) begin
            n_bad++;
            $display("FAIL tout_set got %b/%0d want 1/3", err_timeout, dut.state);
        end
        send(32'h3F800000);
        repeat (6) step();
        n_cmp++;
        if ({busy, err_timeout, 5'(mon_q.size())} !== {1'b0, 1'b1, 5'd1}) begin
            n_bad++;
            $display("FAIL tout_late got %b/%b/%0d want 0/1/1",
                     busy, err_timeout, mon_q.size());
        end
        clear = 1'b1;
        step();
        clear = 1'b0;
        n_cmp++;
        if (err_timeout !== 1'b0) begin
            n_bad++;
            $display("FAIL tout_clear got %b want 0", err_timeout);
        end
    endtask

    task automatic test_unexp();
        do_reset();
        m_ready = 1'b1;
        send(32'h00000001);
        repeat (2) step();
        got = (mon_q.size() > 0) ? mon_q.pop_front() : 52'd0;
        n_cmp++;
        if ({err_unexp, got} !== {1'b1, 32'h00000001, 16'd0, 4'b0001}) begin
            n_bad++;
            $display("FAIL unexp_flag got %b %h want 1 sub idx0", err_unexp, got);
        end
        pulse_issue(1);
        issue = 1'b1;
        send(32'h80000000);
        issue = 1'b0;
        n_cmp++;
        if (outstanding !== 8'd1) begin
            n_bad++;
            $display("FAIL unexp_both got %0d want 1", outstanding);
        end
        send(32'h7F800000);
        repeat (3) step();
        got = (mon_q.size() > 0) ? mon_q.pop_front() : 52'd0;
        n_cmp++;
        if (got !== {32'h80000000, 16'd1, 4'b0010}) begin
            n_bad++;
            $display("FAIL unexp_zero got %h want zero idx1", got);
        end
        got = (mon_q.size() > 0) ? mon_q.pop_front() : 52'd0;
        n_cmp++;
        if (got !== {32'h7F800000, 16'd2, 4'b0100}) begin
            n_bad++;
            $display("FAIL unexp_inf got %h want inf idx2", got);
        end
    endtask

    task automatic test_rst_mid();
        do_reset();
        m_ready = 1'b0;
        pulse_issue(6);
        send(32'h3F800000);
        n_cmp++;
        if ({m_valid, m_data} !== {1'b1, 32'h3F800000}) begin
            n_bad++;
            $display("FAIL latency got %b %h want 1 3f800000", m_valid, m_data);
        end
        for (int i = 1; i < 5; i++)
            send(32'h3F800000 + 32'(i));
        n_cmp++;
        if (outstanding !== 8'd1) begin
            n_bad++;
            $display("FAIL rstmid_outs got %0d want 1", outstanding);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_cmp++;
        if ({m_valid, busy, outstanding, drop_cnt, m_idx, m_data} !== 74'd0) begin
            n_bad++;
            $display("FAIL rstmid_zero got %b %b %0d %0d %0d %h want all 0",
                     m_valid, busy, outstanding, drop_cnt, m_idx, m_data);
        end
        step();
        n_cmp++;
        if (m_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL rstmid_after got %b want 0", m_valid);
        end
    endtask

    initial begin
        rst = 1'b1;
        issue = 1'b0;
        y_valid_in = 1'b0;
        clear = 1'b0;
        m_ready = 1'b0;
        y_in = 32'd0;
        repeat (2) step();
        rst = 1'b0;
        test_reset();
        test_in_order();
        test_overflow();
        test_full_pop();
        test_timeout();
        test_unexp();
        test_rst_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
